// File: rtl/run_reaction_timer.sv
// Reaction timer: random pre-stimulus delay, then counts ticks from lamp-on to button press.
// Flags early presses and missing presses (timeout); result holds until the next trial starts.
module run_reaction_timer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int DELAY_MIN = 1000,
    parameter int MAX_TICKS = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        btn,
    output logic        stim,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        early,
    output logic        timeout
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DLY_W = $clog2(DELAY_MIN + 1024 + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [13:0]      MAX_T    = 14'(MAX_TICKS);

    typedef enum logic [1:0] {IDLE, ARMED, STIM, DONE} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               btn_q;
    logic [DLY_W-1:0]   delay_q, delay_d;
    logic [13:0]        ms_q, ms_d;
    logic [13:0]        result_q, result_d;
    logic               early_q, early_d;
    logic               timeout_q, timeout_d;
    logic               tick, press, accept;

    assign tick   = (div_q == DIV_LAST);
    assign press  = btn & ~btn_q;
    assign accept = (state_q == IDLE) & start;

    // Divider restarts on an accepted start so the first delay tick is a full period away.
    assign div_d  = (accept || tick) ? '0 : div_q + DIV_W'(1);
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        ms_d      = ms_q;
        result_d  = result_q;
        early_d   = early_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    delay_d   = DLY_W'(DELAY_MIN) + DLY_W'(lfsr_q[9:0]);
                    ms_d      = '0;
                    result_d  = '0;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ARMED;
                end
            end
            ARMED: begin
                if (press) begin
                    early_d  = 1'b1;
                    result_d = '0;
                    state_d  = IDLE;
                end else if (tick) begin
                    delay_d = delay_q - DLY_W'(1);
                    if (delay_q == DLY_W'(1)) state_d = STIM;
                end
            end
            STIM: begin
                // A press coinciding with a tick reports the pre-tick count.
                if (press) begin
                    result_d = ms_q;
                    state_d  = DONE;
                end else if (tick) begin
                    if (ms_q >= MAX_T - 14'd1) begin
                        ms_d      = MAX_T;
                        result_d  = MAX_T;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ms_d = ms_q + 14'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            lfsr_q    <= 16'hACE1;
            btn_q     <= 1'b1;
            delay_q   <= '0;
            ms_q      <= '0;
            result_q  <= '0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            lfsr_q    <= lfsr_d;
            btn_q     <= btn;
            delay_q   <= delay_d;
            ms_q      <= ms_d;
            result_q  <= result_d;
            early_q   <= early_d;
            timeout_q <= timeout_d;
        end
    end

    assign stim         = (state_q == STIM);
    assign busy         = (state_q == ARMED) || (state_q == STIM);
    assign result_valid = (state_q == DONE);
    assign result_ms    = result_q;
    assign early        = early_q;
    assign timeout      = timeout_q;
endmodule
